// File: rtl/track_line_scanner.sv
// Track line scanner: pulls a frame from the capture buffer and reads it one word at a time.
// For each row it reports the left edge, right edge and centre of the bright track region.
module track_line_scanner #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    input  logic [7:0]  threshold,
    output logic        DATA_VALID,
    input  logic        DATA_READY,
    output logic [15:0] DualRAM_RADDR,
    input  logic [31:0] DualRAM_RDATA,
    output logic        busy,
    output logic        row_valid,
    output logic [7:0]  row_idx,
    output logic        row_found,
    output logic [7:0]  left_edge,
    output logic [7:0]  right_edge,
    output logic [7:0]  center,
    output logic        frame_done,
    output logic        frame_err
);

    localparam int         HALF_W   = IMG_W / 2;
    localparam logic [7:0] LAST_COL = 8'(HALF_W - 1);
    localparam logic [7:0] LAST_ROW = 8'(IMG_H - 1);
    localparam logic [7:0] MID_COL  = 8'(IMG_W / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_READ,
        S_ROW_END,
        S_RELEASE
    } state_t;

    state_t      r_state;
    logic [7:0]  r_thresh;
    logic [7:0]  r_col;
    logic [7:0]  r_row;
    logic [6:0]  r_pcol;
    logic        r_rd_valid;
    logic [15:0] r_raddr;
    logic [15:0] r_next_addr;
    logic        r_found;
    logic [7:0]  r_left;
    logic [7:0]  r_right;
    logic [7:0]  r_last_center;

    logic        r_data_valid;
    logic        r_busy;
    logic        r_row_valid;
    logic [7:0]  r_row_idx;
    logic        r_row_found;
    logic [7:0]  r_left_edge;
    logic [7:0]  r_right_edge;
    logic [7:0]  r_center;
    logic        r_frame_done;
    logic        r_frame_err;

    logic        w_bright0;
    logic        w_bright1;
    logic [7:0]  w_idx0;
    logic [7:0]  w_idx1;
    logic        w_found_n;
    logic [7:0]  w_left_n;
    logic [7:0]  w_right_n;
    logic [8:0]  w_center_sum;
    logic [7:0]  w_center;
    logic        w_abort;

    // 2R + 2G + B peaks at 219, so 8 bits never overflow.
    function automatic logic [7:0] gray565(input logic [15:0] p);
        return {2'b00, p[15:11], 1'b0} + {1'b0, p[10:5], 1'b0} + {3'b000, p[4:0]};
    endfunction

    // The even pixel precedes the odd one, so it claims the left edge when both are bright.
    always_comb begin
        w_bright0    = r_rd_valid && (gray565(DualRAM_RDATA[15:0])  >= r_thresh);
        w_bright1    = r_rd_valid && (gray565(DualRAM_RDATA[31:16]) >= r_thresh);
        w_idx0       = {r_pcol, 1'b0};
        w_idx1       = {r_pcol, 1'b1};
        w_found_n    = r_found | w_bright0 | w_bright1;
        w_left_n     = r_left;
        if (!r_found) begin
            if (w_bright0) begin
                w_left_n = w_idx0;
            end else if (w_bright1) begin
                w_left_n = w_idx1;
            end
        end
        w_right_n    = r_right;
        if (w_bright1) begin
            w_right_n = w_idx1;
        end else if (w_bright0) begin
            w_right_n = w_idx0;
        end
        w_center_sum = {1'b0, w_left_n} + {1'b0, w_right_n};
        w_center     = w_center_sum[8:1];
        w_abort      = ((r_state == S_READ) || (r_state == S_ROW_END)) && !DATA_READY;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state       <= S_IDLE;
            r_thresh      <= 8'd0;
            r_col         <= 8'd0;
            r_row         <= 8'd0;
            r_pcol        <= 7'd0;
            r_rd_valid    <= 1'b0;
            r_raddr       <= 16'd0;
            r_next_addr   <= 16'd0;
            r_found       <= 1'b0;
            r_left        <= 8'd0;
            r_right       <= 8'd0;
            r_last_center <= MID_COL;
            r_data_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_row_valid   <= 1'b0;
            r_row_idx     <= 8'd0;
            r_row_found   <= 1'b0;
            r_left_edge   <= 8'd0;
            r_right_edge  <= 8'd0;
            r_center      <= 8'd0;
            r_frame_done  <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_row_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_rd_valid   <= (r_state == S_READ) && DATA_READY;
            r_pcol       <= r_col[6:0];

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_thresh      <= threshold;
                        r_last_center <= MID_COL;
                        r_data_valid  <= 1'b1;
                        r_busy        <= 1'b1;
                        r_found       <= 1'b0;
                        r_left        <= 8'd0;
                        r_right       <= 8'd0;
                        r_state       <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (DATA_READY) begin
                        r_row   <= 8'd0;
                        r_col   <= 8'd0;
                        r_raddr <= 16'd0;
                        r_state <= S_READ;
                    end
                end

                S_READ: begin
                    if (w_abort) begin
                        r_state      <= S_IDLE;
                        r_data_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_frame_err  <= 1'b1;
                        r_raddr      <= 16'd0;
                        r_found      <= 1'b0;
                        r_left       <= 8'd0;
                        r_right      <= 8'd0;
                    end else begin
                        r_found <= w_found_n;
                        r_left  <= w_left_n;
                        r_right <= w_right_n;
                        // The next row starts at the word after this one, so remember it.
                        if (r_col == LAST_COL) begin
                            r_next_addr <= r_raddr + 16'd1;
                            r_raddr     <= 16'd0;
                            r_state     <= S_ROW_END;
                        end else begin
                            r_col   <= r_col + 8'd1;
                            r_raddr <= r_raddr + 16'd1;
                        end
                    end
                end

                S_ROW_END: begin
                    if (w_abort) begin
                        r_state      <= S_IDLE;
                        r_data_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_frame_err  <= 1'b1;
                        r_found      <= 1'b0;
                        r_left       <= 8'd0;
                        r_right      <= 8'd0;
                    end else begin
                        r_row_valid <= 1'b1;
                        r_row_idx   <= r_row;
                        r_row_found <= w_found_n;
                        if (w_found_n) begin
                            r_left_edge   <= w_left_n;
                            r_right_edge  <= w_right_n;
                            r_center      <= w_center;
                            r_last_center <= w_center;
                        end else begin
                            r_left_edge  <= 8'd0;
                            r_right_edge <= 8'd0;
                            r_center     <= r_last_center;
                        end
                        r_found <= 1'b0;
                        r_left  <= 8'd0;
                        r_right <= 8'd0;
                        if (r_row == LAST_ROW) begin
                            r_data_valid <= 1'b0;
                            r_state      <= S_RELEASE;
                        end else begin
                            r_row   <= r_row + 8'd1;
                            r_col   <= 8'd0;
                            r_raddr <= r_next_addr;
                            r_state <= S_READ;
                        end
                    end
                end

                S_RELEASE: begin
                    if (!DATA_READY) begin
                        r_frame_done <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign DATA_VALID    = r_data_valid;
    assign DualRAM_RADDR = r_raddr;
    assign busy          = r_busy;
    assign row_valid     = r_row_valid;
    assign row_idx       = r_row_idx;
    assign row_found     = r_row_found;
    assign left_edge     = r_left_edge;
    assign right_edge    = r_right_edge;
    assign center        = r_center;
    assign frame_done    = r_frame_done;
    assign frame_err     = r_frame_err;

endmodule

// File: tb/tb_track_line_scanner.sv
// Bench for track_line_scanner: a per-row reference model fills a scoreboard queue,
// and a monitor pops one entry for every row_valid the scanner emits.
module tb_track_line_scanner;

    localparam int IMG_W      = 160;
    localparam int IMG_H      = 120;
    localparam int HALF_W     = IMG_W / 2;
    localparam int WORDS      = IMG_W * IMG_H / 2;
    localparam int ROW_CYCLES = HALF_W + 1;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        start;
    logic [7:0]  threshold;
    logic        DATA_VALID;
    logic        DATA_READY;
    logic [15:0] DualRAM_RADDR;
    logic [31:0] DualRAM_RDATA;
    logic        busy;
    logic        row_valid;
    logic [7:0]  row_idx;
    logic        row_found;
    logic [7:0]  left_edge;
    logic [7:0]  right_edge;
    logic [7:0]  center;
    logic        frame_done;
    logic        frame_err;

    track_line_scanner #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .start         (start),
        .threshold     (threshold),
        .DATA_VALID    (DATA_VALID),
        .DATA_READY    (DATA_READY),
        .DualRAM_RADDR (DualRAM_RADDR),
        .DualRAM_RDATA (DualRAM_RDATA),
        .busy          (busy),
        .row_valid     (row_valid),
        .row_idx       (row_idx),
        .row_found     (row_found),
        .left_edge     (left_edge),
        .right_edge    (right_edge),
        .center        (center),
        .frame_done    (frame_done),
        .frame_err     (frame_err)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        int row;
        int found;
        int left;
        int right;
        int center;
    } rowRes_t;

    rowRes_t     expQ[$];
    rowRes_t     monExp;
    logic [15:0] pix [IMG_H][IMG_W];
    logic [31:0] mem [WORDS];
    int          capFound  [IMG_H];
    int          capLeft   [IMG_H];
    int          capRight  [IMG_H];
    int          capCenter [IMG_H];

    int errors         = 0;
    int checks         = 0;
    int cycle          = 0;
    int rowsSeen       = 0;
    int frameDoneCount = 0;
    int frameErrCount  = 0;
    int lastRowCycle   = 0;

    // Synchronous-read RAM: data for an address appears one clock later.
    always @(posedge HCLK) begin
        cycle++;
        DualRAM_RDATA <= mem[DualRAM_RADDR];
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    function automatic int gray(input logic [15:0] p);
        return 2 * int'(p[15:11]) + 2 * int'(p[10:5]) + int'(p[4:0]);
    endfunction

    // Scans each row left to right, and also packs the pixels into RAM words.
    task automatic buildExpected(input int thr, input int nRows);
        int      lastC;
        int      first;
        int      last;
        rowRes_t e;
        lastC = IMG_W / 2;
        for (int r = 0; r < IMG_H; r++) begin
            first = -1;
            last  = -1;
            for (int c = 0; c < IMG_W; c++) begin
                if (gray(pix[r][c]) >= thr) begin
                    if (first < 0) first = c;
                    last = c;
                end
            end
            e.row = r;
            if (first >= 0) begin
                e.found  = 1;
                e.left   = first;
                e.right  = last;
                e.center = (first + last) / 2;
                lastC    = e.center;
            end else begin
                e.found  = 0;
                e.left   = 0;
                e.right  = 0;
                e.center = lastC;
            end
            if (r < nRows) expQ.push_back(e);
            for (int w = 0; w < HALF_W; w++) begin
                mem[r * HALF_W + w] = {pix[r][2 * w + 1], pix[r][2 * w]};
            end
        end
    endtask

    task automatic fillEdge();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                pix[r][c] = 16'h0000;
        for (int c = 40; c <= 99; c++) pix[5][c] = 16'hFFFF;
        pix[10][0]         = 16'hFFFF;
        pix[10][IMG_W - 1] = 16'hFFFF;
        pix[11][1]         = 16'hFFFF;
    endtask

    task automatic fillRandom();
        int mode;
        int a;
        int b;
        for (int r = 0; r < IMG_H; r++) begin
            mode = int'($urandom_range(0, 3));
            for (int c = 0; c < IMG_W; c++)
                pix[r][c] = (mode == 1) ? 16'($urandom) : 16'h0000;
            if (mode == 2) begin
                a = int'($urandom_range(0, IMG_W - 1));
                b = int'($urandom_range(a, IMG_W - 1));
                for (int c = a; c <= b; c++) pix[r][c] = 16'hFFFF;
            end
            if (mode == 3) pix[r][$urandom_range(0, IMG_W - 1)] = 16'hFFFF;
        end
    endtask

    // Monitor: compares every emitted row against the head of the scoreboard queue.
    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (row_valid) begin
                rowsSeen++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_row", int'(row_idx), -1);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("row_idx",    int'(row_idx),    monExp.row);
                    checkOutput("row_found",  int'(row_found),  monExp.found);
                    checkOutput("left_edge",  int'(left_edge),  monExp.left);
                    checkOutput("right_edge", int'(right_edge), monExp.right);
                    checkOutput("center",     int'(center),     monExp.center);
                end
                if (row_idx != 8'd0) checkOutput("row_spacing", cycle - lastRowCycle, ROW_CYCLES);
                lastRowCycle = cycle;
                if (int'(row_idx) < IMG_H) begin
                    capFound[row_idx]  = int'(row_found);
                    capLeft[row_idx]   = int'(left_edge);
                    capRight[row_idx]  = int'(right_edge);
                    capCenter[row_idx] = int'(center);
                end
                if (int'(row_idx) == IMG_H - 1) checkOutput("dv_after_last_row", int'(DATA_VALID), 0);
            end
            if (frame_done) frameDoneCount++;
            if (frame_err)  frameErrCount++;
        end
    end

    // One frame: abortRow < 0 runs to completion, otherwise DATA_READY drops during that row.
    task automatic applyStimulus(input int thr, input int holdCycles, input int abortRow);
        int waitCnt;
        rowsSeen       = 0;
        frameDoneCount = 0;
        frameErrCount  = 0;
        buildExpected(thr, (abortRow >= 0) ? abortRow : IMG_H);
        @(negedge HCLK);
        start     = 1'b1;
        threshold = 8'(thr);
        @(negedge HCLK);
        start     = 1'b0;
        threshold = 8'($urandom);
        waitCnt = 0;
        while (!DATA_VALID && waitCnt < 20) begin
            @(negedge HCLK);
            waitCnt++;
        end
        checkOutput("req_data_valid", int'(DATA_VALID), 1);
        for (int i = 0; i < holdCycles; i++) begin
            checkOutput("hold_data_valid", int'(DATA_VALID), 1);
            checkOutput("hold_busy", int'(busy), 1);
            checkOutput("hold_raddr", int'(DualRAM_RADDR), 0);
            @(negedge HCLK);
        end
        DATA_READY = 1'b1;
        if (holdCycles > 0) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge HCLK);
                checkOutput("raddr_seq", int'(DualRAM_RADDR), i);
            end
        end
        if (abortRow >= 0) begin
            waitCnt = 0;
            while (rowsSeen < abortRow && waitCnt < IMG_H * ROW_CYCLES + 200) begin
                @(negedge HCLK);
                waitCnt++;
            end
            checkOutput("abort_rows_reached", rowsSeen, abortRow);
            repeat (10) @(negedge HCLK);
            DATA_READY = 1'b0;
            repeat (4) @(negedge HCLK);
            checkOutput("abort_frame_err", frameErrCount, 1);
            checkOutput("abort_data_valid", int'(DATA_VALID), 0);
            checkOutput("abort_busy", int'(busy), 0);
            checkOutput("abort_frame_done", frameDoneCount, 0);
            checkOutput("abort_rows_seen", rowsSeen, abortRow);
        end else begin
            repeat (100) @(negedge HCLK);
            start     = 1'b1;
            threshold = 8'hFF;
            @(negedge HCLK);
            start = 1'b0;
            waitCnt = 0;
            while (DATA_VALID && waitCnt < IMG_H * ROW_CYCLES + 200) begin
                @(negedge HCLK);
                waitCnt++;
            end
            checkOutput("dv_fall_timeout", int'(DATA_VALID), 0);
            repeat (3) @(negedge HCLK);
            checkOutput("rows_seen", rowsSeen, IMG_H);
            checkOutput("done_before_release", frameDoneCount, 0);
            checkOutput("release_busy", int'(busy), 1);
            DATA_READY = 1'b0;
            repeat (4) @(negedge HCLK);
            checkOutput("frame_done_count", frameDoneCount, 1);
            checkOutput("frame_err_count", frameErrCount, 0);
            checkOutput("idle_busy", int'(busy), 0);
        end
        checkOutput("queue_empty", expQ.size(), 0);
    endtask

    initial begin
        HRESETn    = 1'b0;
        start      = 1'b0;
        DATA_READY = 1'b0;
        threshold  = 8'd0;
        for (int i = 0; i < WORDS; i++) mem[i] = 32'h0;

        repeat (3) @(negedge HCLK);
        start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        @(negedge HCLK);
        checkOutput("rst_data_valid", int'(DATA_VALID), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_raddr", int'(DualRAM_RADDR), 0);
        checkOutput("rst_row_valid", int'(row_valid), 0);
        checkOutput("rst_row_idx", int'(row_idx), 0);
        checkOutput("rst_row_found", int'(row_found), 0);
        checkOutput("rst_left", int'(left_edge), 0);
        checkOutput("rst_right", int'(right_edge), 0);
        checkOutput("rst_center", int'(center), 0);
        checkOutput("rst_frame_done", int'(frame_done), 0);
        checkOutput("rst_frame_err", int'(frame_err), 0);
        HRESETn = 1'b1;
        repeat (5) @(negedge HCLK);
        checkOutput("post_rst_data_valid", int'(DATA_VALID), 0);
        checkOutput("post_rst_busy", int'(busy), 0);

        $display("[TB] edge frame");
        fillEdge();
        applyStimulus(100, 50, -1);
        checkOutput("row0_center", capCenter[0], 80);
        checkOutput("row4_center", capCenter[4], 80);
        checkOutput("row5_found", capFound[5], 1);
        checkOutput("row5_left", capLeft[5], 40);
        checkOutput("row5_right", capRight[5], 99);
        checkOutput("row5_center", capCenter[5], 69);
        checkOutput("row6_found", capFound[6], 0);
        checkOutput("row6_center", capCenter[6], 69);
        checkOutput("row10_left", capLeft[10], 0);
        checkOutput("row10_right", capRight[10], 159);
        checkOutput("row10_center", capCenter[10], 79);
        checkOutput("row11_left", capLeft[11], 1);
        checkOutput("row11_right", capRight[11], 1);

        $display("[TB] random frame");
        fillRandom();
        applyStimulus(int'($urandom_range(40, 200)), 0, -1);

        $display("[TB] aborted frame");
        fillRandom();
        applyStimulus(int'($urandom_range(40, 200)), 0, 30);

        $display("[TB] frame after abort");
        fillRandom();
        applyStimulus(int'($urandom_range(40, 200)), 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/track_line_scanner.md
Name: track_line_scanner

Overview:
- Downstream consumer of the camera frame buffer, clocked on HCLK.
- Requests a frame from the capture stage through the DATA_VALID/DATA_READY handshake, then reads the dual-port RAM read port word by word.
- Each 32-bit word holds two RGB565 pixels. Each pixel is converted to gray and thresholded.
- Per row, emits the left edge, right edge and centre of the bright track region, then releases the buffer so the capture stage can take the next frame.

Parameters:
- IMG_W, 160, pixels per row. Must be even and no more than 256.
- IMG_H, 120, rows per frame. No more than 256. IMG_W*IMG_H/2 must be no more than 65536.

Ports:
- HCLK  input  1  system clock
- HRESETn  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; requests one frame scan
- threshold  input  8  gray threshold; latched when start is accepted
- DATA_VALID  output  1  frame request to the capture stage
- DATA_READY  input  1  capture stage holds a complete frame (HCLK domain, no synchroniser)
- DualRAM_RADDR  output  16  word address to the RAM read port
- DualRAM_RDATA  input  32  RAM read data, valid 1 cycle after the address
- busy  output  1  high in every state except IDLE
- row_valid  output  1  one-cycle pulse; row result fields valid
- row_idx  output  8  row number, 0..IMG_H-1
- row_found  output  1  at least one bright pixel in the row
- left_edge  output  8  index of the first bright pixel
- right_edge  output  8  index of the last bright pixel
- center  output  8  track centre for the row
- frame_done  output  1  one-cycle pulse; all rows emitted
- frame_err  output  1  one-cycle pulse; frame aborted

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Internal last_center resets to IMG_W/2. Asserting reset mid-scan abandons the scan immediately; no pulse is produced.
- FSM states: IDLE, REQ, READ, ROW_END, RELEASE.
- IDLE: on start, latch threshold, set last_center = IMG_W/2 and go to REQ. start is ignored in every other state.
- REQ: DATA_VALID = 1. When DATA_READY = 1, go to READ with row = 0, col = 0.
- READ:
  - DualRAM_RADDR = row*(IMG_W/2) + col.
  - col increments each cycle from 0 to IMG_W/2-1, then the FSM goes to ROW_END.
  - The data for address N is processed in cycle N+1, through a valid flag delayed by one cycle.
- Pixel unpack:
  - Pixel 2c = RDATA[15:0]; pixel 2c+1 = RDATA[31:16].
  - Field layout: R = [15:11], G = [10:5], B = [4:0].
- Gray and threshold:
  - gray = 2*R + 2*G + B, 8-bit, maximum 219, no overflow.
  - A pixel is bright when gray >= threshold.
  - Both pixels of a word are evaluated in the same cycle; the even pixel is treated as first in scan order.
- Edge tracking:
  - The first bright pixel in the row sets left_edge and right_edge and sets row_found.
  - Every later bright pixel updates right_edge.
- ROW_END: lasts one cycle. The final word's data is processed in this cycle, and the row result is registered.
- Row result:
  - row_valid pulses in the cycle after ROW_END. The row fields hold until the next row_valid.
  - If row_found = 1: center = (left_edge + right_edge) >> 1, computed 9-bit before the shift. last_center is updated to this value.
  - If row_found = 0: left_edge = 0, right_edge = 0, center = last_center (last_center unchanged).
  - The edge trackers are cleared for the next row.
- After ROW_END: if row < IMG_H-1, row increments and the FSM returns to READ with col = 0. Otherwise go to RELEASE.
- Throughput: IMG_W/2 + 1 cycles per row. The row_valid pulses for consecutive rows are IMG_W/2 + 1 cycles apart (81 at the defaults).
- RELEASE:
  - DATA_VALID = 0.
  - When DATA_READY = 0, pulse frame_done and go to IDLE.
  - frame_done is asserted after the last row_valid.
- Abort: if DATA_READY falls while in READ or ROW_END, drop DATA_VALID, pulse frame_err, go to IDLE. No further row_valid, no frame_done.
- DATA_VALID is high only in REQ, READ and ROW_END.
- DualRAM_RADDR is 0 outside READ.

Test Plan:
- Reset: HRESETn low with start pulsing -> all outputs 0; DATA_VALID stays 0 until release and a start pulse.
- Handshake: start, DATA_READY held 0 for 50 cycles -> DATA_VALID = 1 and busy = 1 throughout, no RAM addresses issued. Raise DATA_READY -> DualRAM_RADDR = 0 the next cycle, then increments every cycle.
- Edge detection:
  - Setup: threshold = 100. Frame all black except row 5, pixels 40..99 white (0xFFFF).
  - Row 5 -> row_found = 1, left_edge = 40, right_edge = 99, center = 69.
  - Row 6 -> row_found = 0, center = 69.
  - Rows 0..4 -> center = 80.
- Boundary pixels: row with only pixel 0 and pixel 159 white -> left_edge = 0, right_edge = 159, center = 79. Row with only pixel 1 white (odd slot of word 0) -> left_edge = right_edge = 1.
- Frame completion: full frame at defaults -> exactly 120 row_valid pulses with row_idx 0..119 and spacing 81 cycles. DATA_VALID falls after row 119; frame_done pulses once after DATA_READY drops. A start pulse during the scan is ignored.
- Abort: DATA_READY forced low during row 30 -> frame_err pulses once, DATA_VALID = 0, no frame_done. A following start runs a clean full frame.
